// File: rtl/lvds_multi_capture.sv
// lvds_multi_capture: deserialises NUM_LANES serial lanes into per-lane word RAMs (single-shot or ring, optional lane-0 trigger).
// Latency: first sample one edge after START (or on the trigger edge itself); words land on their last-bit edge; reads return 1 cycle after RD_EN.
// Backpressure: none; lanes are sampled every cycle while capturing and a read is accepted every cycle in any state.
module lvds_multi_capture #(
  parameter int NUM_LANES  = 4,
  parameter int DEPTH_BITS = 4096,
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_W     = $clog2(DEPTH_BITS / WORD_WIDTH),
  parameter int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                  LVDS_CLK,
  input  logic                  LVDS_RESET,
  input  logic [NUM_LANES-1:0]  LVDS_IN,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic                  STOP,
  input  logic                  CONT,
  input  logic                  TRIG_EN,
  input  logic                  RD_EN,
  input  logic [LANE_W-1:0]     RD_LANE,
  input  logic [ADDR_W-1:0]     RD_ADDR,
  output logic [WORD_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  WRAPPED,
  output logic [ADDR_W:0]       WORD_COUNT
);

  localparam int NUM_WORDS = DEPTH_BITS / WORD_WIDTH;
  localparam int BIT_W     = $clog2(DEPTH_BITS);
  localparam int WB        = $clog2(WORD_WIDTH);
  localparam logic [ADDR_W:0] WC_MAX   = (ADDR_W + 1)'(NUM_WORDS);
  localparam logic [LANE_W:0] LANE_LIM = (LANE_W + 1)'(NUM_LANES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE
  } state_t;

  state_t                  state_q;
  state_t                  state_nxt;
  logic                    cont_q;
  logic                    prev0_q;
  logic                    stop_pend_q;
  logic                    done_q;
  logic                    wrapped_q;
  logic [BIT_W-1:0]        bit_cnt_q;
  logic [ADDR_W:0]         word_cnt_q;
  logic [WORD_WIDTH-1:0]   shreg_q  [NUM_LANES];
  logic [WORD_WIDTH-1:0]   word_nxt [NUM_LANES];
  logic [WORD_WIDTH-1:0]   mem      [NUM_LANES][NUM_WORDS];
  logic [WORD_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;

  logic                    start_acc;
  logic                    sample;
  logic                    finish;
  logic                    wrap;
  logic                    word_end;
  logic                    last_bit;
  logic                    word_wr;
  logic [ADDR_W-1:0]       wr_addr;
  logic                    lane_ok;

  // A word completes when the low bit-counter field is all ones; the upper field is its address.
  assign word_end = &bit_cnt_q[WB-1:0];
  assign last_bit = &bit_cnt_q;
  assign wr_addr  = bit_cnt_q[BIT_W-1:WB];
  assign word_wr  = sample && word_end && !LVDS_RESET;
  assign lane_ok  = ({1'b0, RD_LANE} < LANE_LIM);

  // State register
  always_ff @(posedge LVDS_CLK) begin
    if (LVDS_RESET) state_q <= ST_IDLE;
    else            state_q <= state_nxt;
  end

  // Next state plus per-cycle capture controls; ABORT outranks START and STOP
  always_comb begin
    state_nxt = state_q;
    start_acc = 1'b0;
    sample    = 1'b0;
    finish    = 1'b0;
    wrap      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!ABORT && START) begin
          start_acc = 1'b1;
          state_nxt = TRIG_EN ? ST_ARMED : ST_CAPTURE;
        end
      end
      ST_ARMED: begin
        if (ABORT) begin
          state_nxt = ST_IDLE;
        end else if (!prev0_q && LVDS_IN[0]) begin
          // The trigger-edge sample itself becomes bit 0
          sample    = 1'b1;
          state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (ABORT) begin
          state_nxt = ST_IDLE;
        end else begin
          sample = 1'b1;
          if (cont_q && word_end && (stop_pend_q || STOP)) begin
            finish    = 1'b1;
            state_nxt = ST_IDLE;
          end else if (last_bit) begin
            if (cont_q) begin
              wrap = 1'b1;
            end else begin
              finish    = 1'b1;
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // LSB-first assembly: new bit enters at the MSB so the first bit ends up in bit 0
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      word_nxt[k] = {LVDS_IN[k], shreg_q[k][WORD_WIDTH-1:1]};
    end
  end

  // Capture datapath, counters and sticky status flags
  always_ff @(posedge LVDS_CLK) begin
    if (LVDS_RESET) begin
      cont_q      <= 1'b0;
      prev0_q     <= 1'b0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      wrapped_q   <= 1'b0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      for (int k = 0; k < NUM_LANES; k++) shreg_q[k] <= '0;
    end else begin
      if (start_acc) begin
        cont_q     <= CONT;
        prev0_q    <= 1'b0;
        done_q     <= 1'b0;
        wrapped_q  <= 1'b0;
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
      end
      if (state_q == ST_ARMED) prev0_q <= LVDS_IN[0];
      if (sample) begin
        // Power-of-two depth: natural counter rollover is the ring wrap
        bit_cnt_q <= bit_cnt_q + 1'b1;
        for (int k = 0; k < NUM_LANES; k++) shreg_q[k] <= word_nxt[k];
        if (word_end && (word_cnt_q != WC_MAX)) word_cnt_q <= word_cnt_q + 1'b1;
      end
      if (wrap)   wrapped_q <= 1'b1;
      if (finish) done_q    <= 1'b1;
      if (ABORT || finish || start_acc) begin
        stop_pend_q <= 1'b0;
      end else if ((state_q == ST_CAPTURE) && cont_q && STOP) begin
        stop_pend_q <= 1'b1;
      end
    end
  end

  // Buffer RAM write: every lane commits its assembled word at the same address
  always_ff @(posedge LVDS_CLK) begin
    if (word_wr) begin
      for (int k = 0; k < NUM_LANES; k++) mem[k][wr_addr] <= word_nxt[k];
    end
  end

  // Registered read port; non-blocking read of mem gives read-first on collisions
  always_ff @(posedge LVDS_CLK) begin
    if (LVDS_RESET) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= RD_EN;
      if (RD_EN) rd_data_q <= lane_ok ? mem[RD_LANE][RD_ADDR] : '0;
    end
  end

  assign RD_DATA    = rd_data_q;
  assign RD_VALID   = rd_valid_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign DONE       = done_q;
  assign WRAPPED    = wrapped_q;
  assign WORD_COUNT = word_cnt_q;

endmodule

// File: tb/tb_lvds_multi_capture.sv
// tb_lvds_multi_capture: directed bench for lvds_multi_capture (4 lanes, 32-bit words, 4096-bit buffers).
// Latency: inputs driven and outputs sampled at the falling edge; the DUT acts on the rising edge between.
// Backpressure: not applicable; stimulus is a fixed linear sequence.
module tb_lvds_multi_capture;
  localparam int NL = 4;
  localparam int DB = 4096;
  localparam int WW = 32;
  localparam int AW = 7;
  localparam int LW = 2;
  localparam int NW = DB / WW;

  logic          clk = 1'b0;
  logic          LVDS_RESET;
  logic [NL-1:0] LVDS_IN;
  logic          START, ABORT, STOP, CONT, TRIG_EN, RD_EN;
  logic [LW-1:0] RD_LANE;
  logic [AW-1:0] RD_ADDR;
  logic [WW-1:0] RD_DATA;
  logic          RD_VALID, BUSY, DONE, WRAPPED;
  logic [AW:0]   WORD_COUNT;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lvds_multi_capture #(
    .NUM_LANES (NL),
    .DEPTH_BITS(DB),
    .WORD_WIDTH(WW)
  ) dut (
    .LVDS_CLK  (clk),
    .LVDS_RESET(LVDS_RESET),
    .LVDS_IN   (LVDS_IN),
    .START     (START),
    .ABORT     (ABORT),
    .STOP      (STOP),
    .CONT      (CONT),
    .TRIG_EN   (TRIG_EN),
    .RD_EN     (RD_EN),
    .RD_LANE   (RD_LANE),
    .RD_ADDR   (RD_ADDR),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .WRAPPED   (WRAPPED),
    .WORD_COUNT(WORD_COUNT)
  );

  // Reference word for a lane/word/run; word 0 always has bit 0 set
  function automatic logic [31:0] pat(int lane, int word, int salt);
    return {8'(salt), 4'(lane), 4'h5, 16'(word * 3 + 1)};
  endfunction

  // Serial bits for sample idx: bit idx%32 of reference word idx/32 on each lane
  function automatic logic [NL-1:0] bits_at(int idx, int salt);
    logic [NL-1:0] b;
    logic [31:0]   w;
    for (int k = 0; k < NL; k++) begin
      w    = pat(k, idx / WW, salt);
      b[k] = w[idx % WW];
    end
    return b;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(string tag, int lane, int addr, logic [31:0] exp);
    RD_EN   = 1'b1;
    RD_LANE = LW'(lane);
    RD_ADDR = AW'(addr);
    tick();
    RD_EN = 1'b0;
    chk({tag, "_vld"}, 32'(RD_VALID), 32'd1);
    chk(tag, RD_DATA, exp);
  endtask

  initial begin
    LVDS_RESET = 1'b1;
    LVDS_IN = '0; START = 1'b0; ABORT = 1'b0; STOP = 1'b0;
    CONT = 1'b0; TRIG_EN = 1'b0; RD_EN = 1'b0; RD_LANE = '0; RD_ADDR = '0;
    tick();
    tick();
    chk("rst_busy",  32'(BUSY),       32'd0);
    chk("rst_done",  32'(DONE),       32'd0);
    chk("rst_wrap",  32'(WRAPPED),    32'd0);
    chk("rst_rdv",   32'(RD_VALID),   32'd0);
    chk("rst_rdd",   RD_DATA,         32'd0);
    chk("rst_wc",    32'(WORD_COUNT), 32'd0);
    LVDS_RESET = 1'b0;
    tick();

    // Single-shot, no trigger: full 4096-bit capture
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("t1_busy_start", 32'(BUSY), 32'd1);
    for (int i = 0; i < DB; i++) begin
      LVDS_IN = bits_at(i, 1);
      tick();
      if (i == 31)      chk("t1_wc_first", 32'(WORD_COUNT), 32'd1);
      if (i == DB - 2) begin
        chk("t1_done_early", 32'(DONE), 32'd0);
        chk("t1_busy_early", 32'(BUSY), 32'd1);
      end
      if (i == DB - 1) begin
        chk("t1_done", 32'(DONE), 32'd1);
        chk("t1_busy", 32'(BUSY), 32'd0);
        chk("t1_wc",   32'(WORD_COUNT), 32'd128);
        chk("t1_wrap", 32'(WRAPPED), 32'd0);
      end
    end
    for (int k = 0; k < NL; k++)
      for (int n = 0; n < NW; n++)
        rd_chk($sformatf("t1_rd_l%0d_w%0d", k, n), k, n, pat(k, n, 1));
    tick();
    chk("t1_rdv_idle", 32'(RD_VALID), 32'd0);
    chk("t1_rdd_hold", RD_DATA, pat(NL - 1, NW - 1, 1));

    // Trigger: lane 0 high at START, low 10 cycles, then rising edge starts capture
    TRIG_EN = 1'b1;
    START   = 1'b1;
    LVDS_IN = '1;
    tick();
    START = 1'b0;
    TRIG_EN = 1'b0;
    chk("t2_armed_busy", 32'(BUSY), 32'd1);
    for (int c = 0; c < 10; c++) begin
      LVDS_IN = 4'b1110;
      tick();
    end
    chk("t2_armed_wc", 32'(WORD_COUNT), 32'd0);
    chk("t2_armed_done", 32'(DONE), 32'd0);
    for (int i = 0; i < 64; i++) begin
      LVDS_IN = bits_at(i, 2);
      tick();
    end
    chk("t2_wc", 32'(WORD_COUNT), 32'd2);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("t2_abort_busy", 32'(BUSY), 32'd0);
    chk("t2_abort_done", 32'(DONE), 32'd0);
    for (int k = 0; k < NL; k++)
      for (int n = 0; n < 3; n++)
        rd_chk($sformatf("t2_rd_l%0d_w%0d", k, n), k, n, (n < 2) ? pat(k, n, 2) : pat(k, n, 1));

    // Continuous ring: wrap, STOP at bit 4166, capture ends after bit 4191
    CONT  = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    CONT  = 1'b0;
    for (int i = 0; i < DB + 96; i++) begin
      LVDS_IN = (i < DB) ? bits_at(i, 3) : bits_at(i - DB, 4);
      STOP    = (i == 4166);
      tick();
      if (i == DB - 2) chk("t3_wrap_early", 32'(WRAPPED), 32'd0);
      if (i == DB - 1) begin
        chk("t3_wrap",      32'(WRAPPED), 32'd1);
        chk("t3_busy_wrap", 32'(BUSY), 32'd1);
        chk("t3_wc_sat",    32'(WORD_COUNT), 32'd128);
      end
      if (i == 4190) begin
        chk("t3_busy_pend", 32'(BUSY), 32'd1);
        chk("t3_done_pend", 32'(DONE), 32'd0);
      end
      if (i == 4191) begin
        chk("t3_done",     32'(DONE), 32'd1);
        chk("t3_busy",     32'(BUSY), 32'd0);
        chk("t3_wrap_end", 32'(WRAPPED), 32'd1);
        chk("t3_wc",       32'(WORD_COUNT), 32'd128);
      end
    end
    STOP = 1'b0;
    for (int k = 0; k < NL; k++)
      for (int n = 0; n < NW; n++)
        rd_chk($sformatf("t3_rd_l%0d_w%0d", k, n), k, n, (n < 3) ? pat(k, n, 4) : pat(k, n, 3));

    // ABORT at bit 40, then ABORT together with START in IDLE
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("t4_done_clr", 32'(DONE), 32'd0);
    for (int i = 0; i < 40; i++) begin
      LVDS_IN = bits_at(i, 5);
      tick();
    end
    chk("t4_wc", 32'(WORD_COUNT), 32'd1);
    LVDS_IN = bits_at(40, 5);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("t4_busy", 32'(BUSY), 32'd0);
    chk("t4_done", 32'(DONE), 32'd0);
    ABORT = 1'b1;
    START = 1'b1;
    tick();
    ABORT = 1'b0;
    START = 1'b0;
    chk("t4_startabort_busy", 32'(BUSY), 32'd0);
    chk("t4_startabort_wc",   32'(WORD_COUNT), 32'd1);
    for (int k = 0; k < NL; k++) begin
      rd_chk($sformatf("t4_rd_l%0d_w0", k), k, 0, pat(k, 0, 5));
      rd_chk($sformatf("t4_rd_l%0d_w1", k), k, 1, pat(k, 1, 4));
    end

    // Read/write collision on lane 2 word 5, then reset mid-capture
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 250; i++) begin
      LVDS_IN = bits_at(i, 6);
      RD_EN   = (i == 191) || (i == 192);
      RD_LANE = 2'd2;
      RD_ADDR = 7'd5;
      tick();
      if (i == 191) begin
        chk("t5_coll_vld", 32'(RD_VALID), 32'd1);
        chk("t5_coll_old", RD_DATA, pat(2, 5, 3));
      end
      if (i == 192) begin
        chk("t5_next_vld", 32'(RD_VALID), 32'd1);
        chk("t5_next_new", RD_DATA, pat(2, 5, 6));
      end
      if (i == 193) begin
        chk("t5_vld_drop", 32'(RD_VALID), 32'd0);
        chk("t5_rdd_hold", RD_DATA, pat(2, 5, 6));
      end
    end
    RD_EN = 1'b0;
    chk("t6_wc_pre", 32'(WORD_COUNT), 32'd7);
    chk("t6_busy_pre", 32'(BUSY), 32'd1);
    LVDS_RESET = 1'b1;
    tick();
    LVDS_RESET = 1'b0;
    chk("t6_busy", 32'(BUSY),       32'd0);
    chk("t6_done", 32'(DONE),       32'd0);
    chk("t6_wrap", 32'(WRAPPED),    32'd0);
    chk("t6_wc",   32'(WORD_COUNT), 32'd0);
    chk("t6_rdv",  32'(RD_VALID),   32'd0);
    chk("t6_rdd",  RD_DATA,         32'd0);

    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < DB; i++) begin
      LVDS_IN = bits_at(i, 7);
      tick();
      if (i == DB - 2) chk("t6_done_early", 32'(DONE), 32'd0);
    end
    chk("t6_done_final", 32'(DONE), 32'd1);
    chk("t6_wc_final",   32'(WORD_COUNT), 32'd128);
    for (int k = 0; k < NL; k++) begin
      rd_chk($sformatf("t6_rd_l%0d_w0", k),   k, 0,   pat(k, 0, 7));
      rd_chk($sformatf("t6_rd_l%0d_w5", k),   k, 5,   pat(k, 5, 7));
      rd_chk($sformatf("t6_rd_l%0d_w127", k), k, 127, pat(k, 127, 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
